// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
//  Module      : move_controller
//  Description : Turn sequencer for the chess board datapath. Converts cursor
//                select/cancel pulses into board RAM reads and writes for one
//                move. Drives the shared piece validator with the current
//                player and the piece under test, and flips the player after
//                every committed move.
//                Optional feature macro: MOVE_CTRL_GAME_OVER_EN
//                (sticky game_over on capture of the opponent king).
//  Revision    : 1.0 - initial release
// ============================================================================
module move_controller #(
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_select,
    input  logic               i_cancel,
    input  logic [ADDR_W-1:0]  i_cursor_addr,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_we,
    output logic [PIECE_W-1:0] o_mem_wdata,
    input  logic [PIECE_W-1:0] i_mem_rdata,
    output logic               o_current_player,
    output logic [PIECE_W-1:0] o_piece_read,
    input  logic               i_piece_valid,
    output logic               o_holding,
    output logic [ADDR_W-1:0]  o_src_addr,
    output logic               o_move_done,
    output logic               o_select_err,
    output logic [PIECE_W-1:0] o_captured_piece,
    output logic               o_game_over
);

    typedef enum logic [3:0] {
        S_WAIT_SRC = 4'd0,
        S_RD_SRC   = 4'd1,
        S_LAT_SRC  = 4'd2,
        S_CHK_SRC  = 4'd3,
        S_WAIT_DST = 4'd4,
        S_RD_DST   = 4'd5,
        S_LAT_DST  = 4'd6,
        S_CHK_DST  = 4'd7,
        S_WR_DST   = 4'd8,
        S_WR_SRC   = 4'd9
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_src_addr;
    logic [ADDR_W-1:0]    r_dst_addr;
    logic [PIECE_W-1:0]   r_held_piece;
    logic [PIECE_W-1:0]   r_target_piece;
    logic [PIECE_W-1:0]   r_captured_piece;
    logic [PIECE_W-1:0]   r_piece_read;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [PIECE_W-1:0]   r_mem_wdata;
    logic                 r_mem_we;
    logic                 r_player;
    logic                 r_holding;
    logic                 r_move_done;

    logic                 w_game_over;
    logic                 w_select;
    logic                 w_cancel;

`ifdef MOVE_CTRL_GAME_OVER_EN
    localparam logic [PIECE_W-1:0] c_BLACK_KING = PIECE_W'(6);
    localparam logic [PIECE_W-1:0] c_WHITE_KING = PIECE_W'(12);

    logic r_game_over;
    logic w_king_hit;

    // White (1) wins by taking the black king, black (0) by taking the white king
    assign w_king_hit  = (r_target_piece == (r_player ? c_BLACK_KING : c_WHITE_KING));
    assign w_game_over = r_game_over;
`else
    assign w_game_over = 1'b0;
`endif

    // Once the game has ended the cursor pulses are simply swallowed
    assign w_select = i_select & ~w_game_over;
    assign w_cancel = i_cancel & ~w_game_over;

    // Move sequencer: state plus every registered output, updated together so
    // each output is valid in the same cycle as the state it belongs to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_WAIT_SRC;
            r_src_addr       <= '0;
            r_dst_addr       <= '0;
            r_held_piece     <= '0;
            r_target_piece   <= '0;
            r_captured_piece <= '0;
            r_piece_read     <= '0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_we         <= 1'b0;
            r_player         <= 1'b0;
            r_holding        <= 1'b0;
            r_move_done      <= 1'b0;
`ifdef MOVE_CTRL_GAME_OVER_EN
            r_game_over      <= 1'b0;
`endif
        end else begin
            // Pulses and write strobes default low; write states re-assert them
            r_move_done <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;

            case (r_state)
                S_WAIT_SRC: begin
                    if (w_select) begin
                        r_src_addr <= i_cursor_addr;
                        r_mem_addr <= i_cursor_addr;
                        r_state    <= S_RD_SRC;
                    end
                end

                S_RD_SRC: begin
                    r_state <= S_LAT_SRC;
                end

                S_LAT_SRC: begin
                    r_held_piece <= i_mem_rdata;
                    r_piece_read <= i_mem_rdata;
                    r_state      <= S_CHK_SRC;
                end

                S_CHK_SRC: begin
                    if (i_piece_valid) begin
                        r_holding <= 1'b1;
                        r_state   <= S_WAIT_DST;
                    end else begin
                        r_state   <= S_WAIT_SRC;
                    end
                end

                S_WAIT_DST: begin
                    if (w_cancel) begin
                        r_holding <= 1'b0;
                        r_state   <= S_WAIT_SRC;
                    end else if (w_select) begin
                        if (i_cursor_addr == r_src_addr) begin
                            r_holding <= 1'b0;
                            r_state   <= S_WAIT_SRC;
                        end else begin
                            r_dst_addr <= i_cursor_addr;
                            r_mem_addr <= i_cursor_addr;
                            r_state    <= S_RD_DST;
                        end
                    end
                end

                S_RD_DST: begin
                    r_state <= S_LAT_DST;
                end

                S_LAT_DST: begin
                    r_target_piece <= i_mem_rdata;
                    r_piece_read   <= i_mem_rdata;
                    r_state        <= S_CHK_DST;
                end

                S_CHK_DST: begin
                    if (i_piece_valid) begin
                        // Own piece on the destination: switch the held piece
                        r_src_addr   <= r_dst_addr;
                        r_held_piece <= r_target_piece;
                        r_piece_read <= r_target_piece;
                        r_mem_addr   <= r_dst_addr;
                        r_state      <= S_WAIT_DST;
                    end else begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_dst_addr;
                        r_mem_wdata  <= r_held_piece;
                        r_piece_read <= r_held_piece;
                        r_state      <= S_WR_DST;
                    end
                end

                S_WR_DST: begin
                    r_mem_we         <= 1'b1;
                    r_mem_addr       <= r_src_addr;
                    r_mem_wdata      <= '0;
                    r_move_done      <= 1'b1;
                    r_captured_piece <= r_target_piece;
                    r_state          <= S_WR_SRC;
                end

                S_WR_SRC: begin
                    r_holding <= 1'b0;
                    r_state   <= S_WAIT_SRC;
`ifdef MOVE_CTRL_GAME_OVER_EN
                    // The winning side keeps the turn; the board is frozen
                    if (w_king_hit) begin
                        r_game_over <= 1'b1;
                    end else begin
                        r_player <= ~r_player;
                    end
`else
                    r_player  <= ~r_player;
`endif
                end

                default: begin
                    r_holding  <= 1'b0;
                    r_mem_addr <= r_src_addr;
                    r_state    <= S_WAIT_SRC;
                end
            endcase
        end
    end

    // The rejection has to appear in the check cycle itself, so it is decoded
    // from the state and the combinational validator answer
    assign o_select_err = (r_state == S_CHK_SRC) && !i_piece_valid;

    assign o_mem_addr       = r_mem_addr;
    assign o_mem_we         = r_mem_we;
    assign o_mem_wdata      = r_mem_wdata;
    assign o_current_player = r_player;
    assign o_piece_read     = r_piece_read;
    assign o_holding        = r_holding;
    assign o_src_addr       = r_src_addr;
    assign o_move_done      = r_move_done;
    assign o_captured_piece = r_captured_piece;
    assign o_game_over      = w_game_over;

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_move_controller
//  Description : Self-checking bench for move_controller. A transaction-level
//                model predicts a per-cycle timeline of every output from the
//                turn rules; a compare process checks the DUT against it on
//                each falling edge. Directed moves pin the model with literal
//                expectations, then random select/cancel traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_move_controller;
    localparam int AW   = 6;
    localparam int PW   = 4;
    localparam int MAXC = 8000;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          sel    = 1'b0;
    logic          can    = 1'b0;
    logic [AW-1:0] cur    = '0;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;
    logic          player;
    logic [PW-1:0] piece_read;
    logic          piece_valid;
    logic          holding;
    logic [AW-1:0] src_addr;
    logic          move_done;
    logic          select_err;
    logic [PW-1:0] captured;
    logic          game_over;

    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_wa = '0;
    logic [PW-1:0] tb_wd = '0;
    logic [PW-1:0] ram [64];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // Expected per-cycle timeline
    logic          e_we   [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [PW-1:0] e_wd   [MAXC];
    logic          e_done [MAXC];
    logic          e_err  [MAXC];
    logic          e_hold [MAXC];
    logic [AW-1:0] e_src  [MAXC];
    logic          e_pl   [MAXC];
    logic [PW-1:0] e_pr   [MAXC];
    logic [PW-1:0] e_cap  [MAXC];
    logic          e_go   [MAXC];

    // Model state
    int            m_ready = 0;
    bit            m_mode  = 1'b0;   // 0: waiting for source, 1: holding
    logic [AW-1:0] m_src   = '0;
    logic [PW-1:0] m_held  = '0;
    bit            m_pl    = 1'b0;
    bit            m_go    = 1'b0;
    logic [PW-1:0] mboard [64];
    logic [PW-1:0] snap   [64];
    int            snap_cyc = -1;

    // Observation counters
    int            wr_cnt   = 0;
    int            done_cnt = 0;
    int            err_cnt  = 0;
    logic [PW-1:0] last_cap = '0;

    always #5 clk = ~clk;

    move_controller #(.ADDR_W(AW), .PIECE_W(PW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_select         (sel),
        .i_cancel         (can),
        .i_cursor_addr    (cur),
        .o_mem_addr       (mem_addr),
        .o_mem_we         (mem_we),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .o_current_player (player),
        .o_piece_read     (piece_read),
        .i_piece_valid    (piece_valid),
        .o_holding        (holding),
        .o_src_addr       (src_addr),
        .o_move_done      (move_done),
        .o_select_err     (select_err),
        .o_captured_piece (captured),
        .o_game_over      (game_over)
    );

    function automatic bit owns(input logic [PW-1:0] p, input logic pl);
        if (pl) return (p >= 4'd7 && p <= 4'd12);
        return (p >= 4'd1 && p <= 4'd6);
    endfunction

    // Ownership-only validator
    assign piece_valid = owns(piece_read, player);

    // Board RAM: one port, synchronous read; bench back door when DUT is idle
    always @(posedge clk) begin
        if (mem_we)     ram[mem_addr] <= mem_wdata;
        else if (tb_we) ram[tb_wa]    <= tb_wd;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs against the predicted timeline
    always @(negedge clk) begin
        if (chk_on && resetn && cyc < MAXC) begin
            chk("mem_we",     16'(mem_we),     16'(e_we[cyc]));
            chk("mem_addr",   16'(mem_addr),   16'(e_addr[cyc]));
            chk("mem_wdata",  16'(mem_wdata),  16'(e_wd[cyc]));
            chk("move_done",  16'(move_done),  16'(e_done[cyc]));
            chk("select_err", 16'(select_err), 16'(e_err[cyc]));
            chk("holding",    16'(holding),    16'(e_hold[cyc]));
            chk("src_addr",   16'(src_addr),   16'(e_src[cyc]));
            chk("player",     16'(player),     16'(e_pl[cyc]));
            chk("piece_read", 16'(piece_read), 16'(e_pr[cyc]));
            chk("game_over",  16'(game_over),  16'(e_go[cyc]));
            if (e_done[cyc]) chk("captured", 16'(captured), 16'(e_cap[cyc]));
        end
    end

    // Event counters used by the literal expectations
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_we)     wr_cnt++;
            if (select_err) err_cnt++;
            if (move_done) begin
                done_cnt++;
                last_cap = captured;
            end
        end
    end

    task automatic f_src(input int k, input logic [AW-1:0] v);
        for (int i = k; i < MAXC; i++) begin e_src[i] = v; e_addr[i] = v; end
    endtask
    task automatic f_hold(input int k, input logic v);
        for (int i = k; i < MAXC; i++) e_hold[i] = v;
    endtask
    task automatic f_pl(input int k, input logic v);
        for (int i = k; i < MAXC; i++) e_pl[i] = v;
    endtask
    task automatic f_pr(input int k, input logic [PW-1:0] v);
        for (int i = k; i < MAXC; i++) e_pr[i] = v;
    endtask
    task automatic f_cap(input int k, input logic [PW-1:0] v);
        for (int i = k; i < MAXC; i++) e_cap[i] = v;
    endtask
    task automatic f_go(input int k, input logic v);
        for (int i = k; i < MAXC; i++) e_go[i] = v;
    endtask
    task automatic f_reset(input int k);
        f_src(k, '0); f_hold(k, 1'b0); f_pl(k, 1'b0); f_pr(k, '0); f_cap(k, '0); f_go(k, 1'b0);
        for (int i = k; i < MAXC; i++) begin
            e_we[i] = 1'b0; e_wd[i] = '0; e_done[i] = 1'b0; e_err[i] = 1'b0;
        end
    endtask

    // Predict the effect of a select/cancel pulse sampled at rising edge T
    task automatic m_event(input int T, input bit s, input bit c, input logic [AW-1:0] a);
        logic [PW-1:0] t;
        if (!s && !c) return;
        if (T - 1 < m_ready || m_go) return;
        if (!m_mode) begin
            if (!s) return;
            m_src = a;
            f_src(T, a);
            t = mboard[a];
            m_held = t;
            f_pr(T + 2, t);
            m_ready = T + 3;
            if (owns(t, m_pl)) begin
                m_mode = 1'b1;
                f_hold(T + 3, 1'b1);
            end else begin
                e_err[T + 2] = 1'b1;
            end
        end else if (c || a == m_src) begin
            m_mode  = 1'b0;
            f_hold(T, 1'b0);
            m_ready = T;
        end else begin
            t = mboard[a];
            for (int i = T; i < T + 3; i++) e_addr[i] = a;
            f_pr(T + 2, t);
            if (owns(t, m_pl)) begin
                m_src  = a;
                f_src(T + 3, a);
                m_held = t;
                f_pr(T + 3, t);
                m_ready = T + 3;
            end else begin
                snap     = mboard;
                snap_cyc = T + 3;
                e_we[T + 3] = 1'b1; e_addr[T + 3] = a;     e_wd[T + 3] = m_held;
                e_we[T + 4] = 1'b1; e_addr[T + 4] = m_src; e_wd[T + 4] = '0;
                e_done[T + 4] = 1'b1;
                f_cap(T + 4, t);
                f_pr(T + 3, m_held);
                mboard[a]     = m_held;
                mboard[m_src] = '0;
                m_mode  = 1'b0;
                f_hold(T + 5, 1'b0);
                m_ready = T + 5;
`ifdef MOVE_CTRL_GAME_OVER_EN
                if (t == (m_pl ? 4'd6 : 4'd12)) begin
                    m_go = 1'b1;
                    f_go(T + 5, 1'b1);
                end else begin
                    m_pl = !m_pl;
                    f_pl(T + 5, m_pl);
                end
`else
                m_pl = !m_pl;
                f_pl(T + 5, m_pl);
`endif
            end
        end
    endtask

    task automatic do_sel(input logic [AW-1:0] a, input bit s, input bit c);
        @(negedge clk);
        cur = a; sel = s; can = c;
        m_event(cyc + 1, s, c, a);
        @(negedge clk);
        sel = 1'b0; can = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cyc < m_ready) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL wait_ready: cycle %0d never reached ready %0d", cyc, m_ready);
                break;
            end
        end
    endtask

    task automatic setsq(input logic [AW-1:0] a, input logic [PW-1:0] v);
        @(negedge clk);
        tb_wa = a; tb_wd = v; tb_we = 1'b1;
        mboard[a] = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Called on a falling edge: asynchronous reset in the middle of a cycle
    task automatic mid_reset();
        int k;
        #1 resetn = 1'b0;
        k = cyc;
        f_reset(k);
        if (k <= snap_cyc) mboard = snap;
        snap_cyc = -1;
        m_mode = 1'b0; m_ready = k; m_src = '0; m_held = '0; m_pl = 1'b0; m_go = 1'b0;
        #1;
        chk("rst_holding", 16'(holding),   16'd0);
        chk("rst_mem_we",  16'(mem_we),    16'd0);
        chk("rst_src",     16'(src_addr),  16'd0);
        chk("rst_player",  16'(player),    16'd0);
        chk("rst_done",    16'(move_done), 16'd0);
        chk("rst_go",      16'(game_over), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        int w0;
        int e0;
        int d0;
        logic [AW-1:0] a;
        int r;

        f_reset(0);
        for (int i = 0; i < 64; i++) setsq(6'(i), 4'd0);
        @(negedge clk);
        #1 resetn = 1'b1;
        chk_on  = 1'b1;
        m_ready = cyc;

        // Reset values
        chk("init_holding",  16'(holding),   16'd0);
        chk("init_player",   16'(player),    16'd0);
        chk("init_src",      16'(src_addr),  16'd0);
        chk("init_captured", 16'(captured),  16'd0);
        chk("init_mem_we",   16'(mem_we),    16'd0);
        chk("init_go",       16'(game_over), 16'd0);

        // Wrong owner: black to move selects a white piece
        setsq(6'd50, 4'd9);
        w0 = wr_cnt; e0 = err_cnt;
        do_sel(6'd50, 1'b1, 1'b0);
        wait_ready();
        @(negedge clk);
        chk("wrong_owner_err",  16'(err_cnt - e0), 16'd1);
        chk("wrong_owner_hold", 16'(holding),      16'd0);
        chk("wrong_owner_wr",   16'(wr_cnt - w0),  16'd0);

        // Legal quiet move 12 -> 28
        setsq(6'd12, 4'd3);
        setsq(6'd28, 4'd0);
        do_sel(6'd12, 1'b1, 1'b0);
        wait_ready();
        chk("legal_hold", 16'(holding),  16'd1);
        chk("legal_src",  16'(src_addr), 16'd12);
        w0 = wr_cnt; d0 = done_cnt;
        do_sel(6'd28, 1'b1, 1'b0);
        wait_ready();
        @(negedge clk);
        chk("legal_ram28",  16'(ram[28]),        16'd3);
        chk("legal_ram12",  16'(ram[12]),        16'd0);
        chk("legal_writes", 16'(wr_cnt - w0),    16'd2);
        chk("legal_done",   16'(done_cnt - d0),  16'd1);
        chk("legal_cap",    16'(last_cap),       16'd0);
        chk("legal_player", 16'(player),         16'd1);

        // Reselect: white holds 20, picks own piece on 21
        setsq(6'd20, 4'd9);
        setsq(6'd21, 4'd10);
        do_sel(6'd20, 1'b1, 1'b0);
        wait_ready();
        w0 = wr_cnt;
        do_sel(6'd21, 1'b1, 1'b0);
        wait_ready();
        chk("resel_src",    16'(src_addr),    16'd21);
        chk("resel_hold",   16'(holding),     16'd1);
        chk("resel_wr",     16'(wr_cnt - w0), 16'd0);
        chk("resel_player", 16'(player),      16'd1);

        // Deselect by selecting the held square
        do_sel(6'd21, 1'b1, 1'b0);
        wait_ready();
        chk("desel_hold", 16'(holding), 16'd0);

        // Cancel beats a simultaneous select
        do_sel(6'd21, 1'b1, 1'b0);
        wait_ready();
        w0 = wr_cnt;
        do_sel(6'd40, 1'b1, 1'b1);
        wait_ready();
        @(negedge clk);
        chk("cancel_hold", 16'(holding),     16'd0);
        chk("cancel_wr",   16'(wr_cnt - w0), 16'd0);

        // White captures the black king
        setsq(6'd4, 4'd6);
        do_sel(6'd21, 1'b1, 1'b0);
        wait_ready();
        do_sel(6'd4, 1'b1, 1'b0);
        wait_ready();
        @(negedge clk);
        chk("king_cap", 16'(last_cap), 16'd6);
`ifdef MOVE_CTRL_GAME_OVER_EN
        chk("king_go",     16'(game_over), 16'd1);
        chk("king_player", 16'(player),    16'd1);
        w0 = wr_cnt;
        setsq(6'd30, 4'd10);
        do_sel(6'd30, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        chk("go_frozen_wr",   16'(wr_cnt - w0), 16'd0);
        chk("go_frozen_hold", 16'(holding),     16'd0);
`else
        chk("king_go",     16'(game_over), 16'd0);
        chk("king_player", 16'(player),    16'd0);
`endif

        // Reset in the middle of a move (during the destination read)
        @(negedge clk);
        mid_reset();
        setsq(6'd8, 4'd2);
        setsq(6'd9, 4'd0);
        do_sel(6'd8, 1'b1, 1'b0);
        wait_ready();
        w0 = wr_cnt;
        do_sel(6'd9, 1'b1, 1'b0);
        mid_reset();
        repeat (8) @(negedge clk);
        chk("midrst_wr",   16'(wr_cnt - w0), 16'd0);
        chk("midrst_ram8", 16'(ram[8]),      16'd2);
        chk("midrst_ram9", 16'(ram[9]),      16'd0);

        // Random board and random cursor traffic
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 15);
            setsq(6'(i), (r > 12) ? 4'd0 : 4'(r));
        end
        for (int it = 0; it < 400 && cyc < MAXC - 300; it++) begin
            r = $urandom_range(0, 9);
            a = 6'($urandom_range(0, 63));
            if (r <= 5)      do_sel(a, 1'b1, 1'b0);
            else if (r == 6) do_sel(a, 1'b0, 1'b1);
            else if (r == 7) do_sel(a, 1'b1, 1'b1);
            else if (r == 8) repeat ($urandom_range(1, 3)) @(negedge clk);
            else if (m_mode) do_sel(m_src, 1'b1, 1'b0);
            if ($urandom_range(0, 3) != 0) wait_ready();
        end
        wait_ready();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) chk("board", 16'(ram[i]), 16'(mboard[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/move_controller.md
# move_controller

Turn sequencer for the chess board datapath. Takes square-select pulses from the cursor/input handler and performs the board RAM reads and writes for a move. It drives the shared piece validator with the current player and the piece under test, and toggles the player after each completed move. It sits between the input handler, the board RAM (one read/write port) and the piece validator.

## Interface
- `ADDR_W`, default 6: board square address width (64 squares).
- `PIECE_W`, default 4: piece code width. Code 0 is empty, 1–6 are black, 7–12 are white; 6 and 12 are the kings.

- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `select`  in  1  one-cycle pulse; cursor square chosen.
- `cancel`  in  1  one-cycle pulse; drop the held piece.
- `cursor_addr`  in  ADDR_W  square addressed by `select`.
- `mem_addr`  out  ADDR_W  board RAM address.
- `mem_we`  out  1  board RAM write enable.
- `mem_wdata`  out  PIECE_W  board RAM write data.
- `mem_rdata`  in  PIECE_W  board RAM read data; one-cycle synchronous read latency.
- `current_player`  out  1  0 is black, 1 is white; feeds the validator.
- `piece_read`  out  PIECE_W  piece under test; feeds the validator.
- `piece_valid`  in  1  validator result for `piece_read`/`current_player`; combinational.
- `holding`  out  1  a source piece is selected.
- `src_addr`  out  ADDR_W  selected source square, for the highlight.
- `move_done`  out  1  one-cycle pulse; move committed.
- `select_err`  out  1  one-cycle pulse; source select rejected.
- `captured_piece`  out  PIECE_W  prior contents of the destination; valid while `move_done` is high.
- `game_over`  out  1  see Configuration.

## Operation
- States:
  - WAIT_SRC: idle.
  - RD_SRC and LAT_SRC: source read and capture.
  - CHK_SRC: source check.
  - WAIT_DST: holding a piece.
  - RD_DST and LAT_DST: destination read and capture.
  - CHK_DST: destination check.
  - WR_DST and WR_SRC: board writes.
- WAIT_SRC + `select`:
  - Latch `cursor_addr` into `src_addr`.
  - Go to RD_SRC.
- RD_SRC: `mem_addr` = `src_addr`. LAT_SRC: capture `mem_rdata` into `held_piece`.
- CHK_SRC: `piece_read` = `held_piece`.
  - If `piece_valid` = 1: go to WAIT_DST.
  - Otherwise: pulse `select_err` and return to WAIT_SRC.
- WAIT_DST:
  - `cancel` returns to WAIT_SRC.
  - `select` with `cursor_addr` == `src_addr` deselects and returns to WAIT_SRC.
  - `select` with any other square latches `dst_addr` and goes to RD_DST.
- RD_DST / LAT_DST: `mem_addr` = `dst_addr`; capture `mem_rdata` into `target_piece`.
- CHK_DST: `piece_read` = `target_piece`.
  - If `piece_valid` = 1 (own piece): reselect. `src_addr` ← `dst_addr`, `held_piece` ← `target_piece`, stay in WAIT_DST. No write, no error.
  - Otherwise: go to WR_DST.
- WR_DST: `mem_we` = 1, `mem_addr` = `dst_addr`, `mem_wdata` = `held_piece`.
- WR_SRC:
  - Board write: `mem_we` = 1, `mem_addr` = `src_addr`, `mem_wdata` = 0.
  - Outputs: `move_done` = 1, `captured_piece` = `target_piece`.
  - Next: `current_player` toggles on exit; go to WAIT_SRC.
- `piece_read` = `held_piece` in every state except CHK_DST. `piece_valid` is used only in CHK_SRC and CHK_DST.
- `select` and `cancel` are ignored outside the WAIT states. If both are high in WAIT_DST, `cancel` wins. `cancel` in WAIT_SRC has no effect.
- `holding` = 1 in WAIT_DST through WR_SRC.
- Outside the write states `mem_we` = 0, `mem_wdata` = 0, and `mem_addr` = `src_addr`.
- Move legality per piece type is not checked here; only ownership is.

## Timing
- Reset (asynchronous assert):
  - State is WAIT_SRC.
  - `current_player`, `src_addr`, `dst_addr`, `held_piece`, `target_piece`, `captured_piece` = 0.
  - `move_done`, `select_err`, `mem_we`, `holding`, `game_over` = 0.
- Reset mid-move (including during WR_DST) aborts immediately. No further writes occur. A half-written board is the caller's responsibility.
- Source select on edge T:
  - RD_SRC at T+1.
  - LAT_SRC at T+2.
  - CHK_SRC at T+3.
  - `select_err` high during T+3, or `holding` high from T+4.
- Destination select on edge T:
  - RD_DST at T+1, LAT_DST at T+2, CHK_DST at T+3.
  - WR_DST at T+4 (`mem_we` high).
  - WR_SRC at T+5 (`mem_we` high, `move_done` high).
  - `current_player` flips at T+6.
- Minimum select spacing is 1 cycle. Pulses during busy states are dropped, not queued.

## Configuration
- `MOVE_CTRL_GAME_OVER_EN` defined:
  - In WR_SRC, if `target_piece` is the opponent king (6 when white moves, 12 when black moves), `game_over` sets sticky.
  - While `game_over` = 1, all `select`/`cancel` are ignored and `current_player` does not toggle.
  - Only reset clears `game_over`.
- Undefined:
  - `game_over` tied to 0.
  - No king comparison logic is built.

## Test plan
- Legal move. Reset, board[12]=3, board[28]=0. `select` 12 then `select` 28:
  - `mem_we` at T+4 writes 3 to addr 28.
  - `mem_we` at T+5 writes 0 to addr 12.
  - `move_done` pulses once, `captured_piece`=0, `current_player`=1 afterwards.
- Wrong owner. Black to move, board[50]=9. `select` 50:
  - `select_err` pulses at T+3.
  - `holding` stays 0, no writes.
- Reselect. Black holding 12, board[13]=4. `select` 13:
  - `src_addr`=13, still WAIT_DST.
  - No `mem_we`, `current_player` unchanged.
- Deselect and cancel:
  - Holding 12, `select` 12: returns to WAIT_SRC, `holding`=0.
  - Repeat the hold, then `cancel` and `select` in the same cycle: cancel wins.
- Capture and game over. With the macro, white captures board[4]=6:
  - `captured_piece`=6 and `game_over`=1.
  - Subsequent `select` pulses cause no reads or writes.
  - Without the macro, `game_over` stays 0 and the player toggles.
- Reset mid-move. Assert `resetn`=0 during RD_DST:
  - All outputs return to reset values immediately.
  - No `mem_we` occurs afterwards.
